// File: rtl/bp_pkg.sv
// Shared types and helpers for the decode-stage branch predictor.
package bp_pkg;

   typedef logic [1:0] counter_t;

   localparam counter_t SNT = 2'd0;
   localparam counter_t WNT = 2'd1;
   localparam counter_t WT  = 2'd2;
   localparam counter_t ST  = 2'd3;

   localparam logic [4:0] X1 = 5'd1;
   localparam logic [4:0] X5 = 5'd5;

   // Link registers per the RISC-V calling convention hint rules.
   function automatic logic is_link(input logic [4:0] r);
      return (r == X1) || (r == X5);
   endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: push, pop, or replace-top when both requested.
module bp_ras #(
   parameter int unsigned RAS_DEPTH = 8,
   parameter int unsigned XLEN      = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic                             pop,
   input  logic [XLEN-1:0]                  push_data,
   output logic [XLEN-1:0]                  top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   count
);

   localparam int unsigned PTRW = $clog2(RAS_DEPTH);
   localparam int unsigned CNTW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] stack_q [RAS_DEPTH];
   logic [PTRW-1:0] ptr_q;
   logic [CNTW-1:0] count_q;
   logic [PTRW-1:0] top_idx;
   logic            empty;
   logic            full;

   assign top_idx = ptr_q - PTRW'(1);
   assign top     = stack_q[top_idx];
   assign count   = count_q;
   assign empty   = (count_q == '0);
   assign full    = (count_q == CNTW'(RAS_DEPTH));

   // ptr_q points at the next free slot; wraps so a full push drops the oldest entry.
   // A pop on an empty stack is a no-op, so pop+push on empty degrades to a plain push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
         ptr_q   <= '0;
         count_q <= '0;
      end else if (push && pop && !empty) begin
         stack_q[top_idx] <= push_data;
      end else if (push) begin
         stack_q[ptr_q] <= push_data;
         ptr_q          <= ptr_q + PTRW'(1);
         if (!full) count_q <= count_q + CNTW'(1);
      end else if (pop && !empty) begin
         ptr_q   <= ptr_q - PTRW'(1);
         count_q <= count_q - CNTW'(1);
      end
   end

endmodule

// File: rtl/branch_predictor_gras.sv
// Decode-stage predictor: gshare/bimodal 2-bit counters plus a return-address stack,
// trained non-speculatively from EX.
module branch_predictor_gras
   import bp_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned GHR_BITS    = 6,
   parameter int unsigned RAS_DEPTH   = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           id_valid,
   input  logic [XLEN-1:0]                id_pc,
   input  logic [XLEN-1:0]                id_imm,
   input  logic                           id_is_branch,
   input  logic                           id_is_jal,
   input  logic                           id_is_jalr,
   input  logic [4:0]                     id_rs1,
   input  logic [4:0]                     id_rd,
   input  logic [XLEN-1:0]                id_rs1_data,
   input  logic                           ex_valid,
   input  logic [XLEN-1:0]                ex_pc,
   input  logic [XLEN-1:0]                ex_target,
   input  logic                           ex_taken,
   input  logic                           ex_predicted,
   input  logic [$clog2(BHT_ENTRIES)-1:0] ex_idx,
   output logic [XLEN-1:0]                target_pc,
   output logic                           predict_taken,
   output logic [$clog2(BHT_ENTRIES)-1:0] pred_idx,
   output logic                           mispredict,
   output logic [XLEN-1:0]                recover_pc
);

   localparam int unsigned IDXW = $clog2(BHT_ENTRIES);
   localparam int unsigned CNTW = $clog2(RAS_DEPTH + 1);

   counter_t        bht_q [BHT_ENTRIES];
   logic [IDXW-1:0] ghr_idx;
   logic [IDXW-1:0] idx_c;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_imm;
   logic [XLEN-1:0] jalr_calc;
   logic            jalr_pop;
   logic            ras_push;
   logic            ras_pop;
   logic [XLEN-1:0] ras_top;
   logic [CNTW-1:0] ras_count;
   logic            ctr_taken;
   logic            id_update;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^{id_pc[XLEN-1:IDXW+2], id_pc[1:0]};

   // Global history shifts in resolved outcomes; absent entirely for pure bimodal.
   if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                   ghr_q <= '0;
         else if (ex_valid && !stall) ghr_q <= GHR_BITS'({ghr_q, ex_taken});
      end
      assign ghr_idx = IDXW'(ghr_q);
   end else begin : g_no_ghr
      assign ghr_idx = '0;
   end

   assign idx_c     = id_pc[IDXW+1:2] ^ ghr_idx;
   assign pred_idx  = idx_c;
   assign ctr_taken = bht_q[idx_c][1];

   // Saturating counter training; ID reads above see the pre-edge value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= WNT;
      end else if (ex_valid && !stall) begin
         if (ex_taken && bht_q[ex_idx] != ST)
            bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
         else if (!ex_taken && bht_q[ex_idx] != SNT)
            bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
      end
   end

   assign pc_plus4  = id_pc + XLEN'(4);
   assign pc_imm    = id_pc + id_imm;
   assign jalr_calc = (id_rs1_data + id_imm) & ~XLEN'(1);
   assign jalr_pop  = id_is_jalr && is_link(id_rs1) && (id_rs1 != id_rd);
   assign id_update = id_valid && !stall;
   assign ras_push  = id_update && (id_is_jal || id_is_jalr) && is_link(id_rd);
   assign ras_pop   = id_update && jalr_pop;

   bp_ras #(
      .RAS_DEPTH (RAS_DEPTH),
      .XLEN      (XLEN)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus4),
      .top       (ras_top),
      .count     (ras_count)
   );

   // Same-cycle next-PC selection; reset forces the sequential fall-through.
   always_comb begin
      predict_taken = 1'b0;
      target_pc     = pc_plus4;
      if (rst && id_valid) begin
         if (id_is_jal) begin
            predict_taken = 1'b1;
            target_pc     = pc_imm;
         end else if (id_is_jalr) begin
            predict_taken = 1'b1;
            target_pc     = (jalr_pop && ras_count != '0) ? ras_top : jalr_calc;
         end else if (id_is_branch) begin
            predict_taken = ctr_taken;
            target_pc     = ctr_taken ? pc_imm : pc_plus4;
         end
      end
   end

   assign mispredict = rst && ex_valid && (ex_taken != ex_predicted);
   assign recover_pc = !rst ? '0 : (ex_taken ? ex_target : ex_pc + XLEN'(4));

endmodule

// File: tb/tb_branch_predictor_gras.sv
// Directed bench for branch_predictor_gras: counters, GHR indexing, RAS, recovery, stall, reset.
module tb_branch_predictor_gras;

   localparam int unsigned XLEN = 32;
   localparam int unsigned IDXW = 6;

   logic            clk;
   logic            rst;
   logic            stall;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_imm;
   logic            id_is_branch;
   logic            id_is_jal;
   logic            id_is_jalr;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rd;
   logic [XLEN-1:0] id_rs1_data;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_target;
   logic            ex_taken;
   logic            ex_predicted;
   logic [IDXW-1:0] ex_idx;
   logic [XLEN-1:0] target_pc;
   logic            predict_taken;
   logic [IDXW-1:0] pred_idx;
   logic            mispredict;
   logic [XLEN-1:0] recover_pc;

   int pass_cnt = 0;
   int total    = 0;
   logic [5:0] ghr_m = '0;

   branch_predictor_gras #(
      .XLEN(32), .BHT_ENTRIES(64), .GHR_BITS(6), .RAS_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
      .id_is_branch(id_is_branch), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
      .id_rs1(id_rs1), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_taken(ex_taken), .ex_predicted(ex_predicted), .ex_idx(ex_idx),
      .target_pc(target_pc), .predict_taken(predict_taken), .pred_idx(pred_idx),
      .mispredict(mispredict), .recover_pc(recover_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_valid = 0; id_pc = '0; id_imm = '0; id_is_branch = 0; id_is_jal = 0;
      id_is_jalr = 0; id_rs1 = '0; id_rd = '0; id_rs1_data = '0;
      ex_valid = 0; ex_pc = '0; ex_target = '0; ex_taken = 0; ex_predicted = 0; ex_idx = '0;
   endtask

   task automatic set_id(input logic br, input logic jal, input logic jalr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rd,
                         input logic [31:0] rs1_data);
      id_valid = 1; id_is_branch = br; id_is_jal = jal; id_is_jalr = jalr;
      id_pc = pc; id_imm = imm; id_rs1 = rs1; id_rd = rd; id_rs1_data = rs1_data;
   endtask

   task automatic train(input logic [5:0] idx, input logic t);
      ex_valid = 1; ex_idx = idx; ex_taken = t; ex_predicted = t;
      ex_pc = 32'h100; ex_target = 32'h120;
      tick();
      ex_valid = 0;
      ghr_m = {ghr_m[4:0], t};
   endtask

   task automatic test_reset();
      rst = 0; stall = 0; clear_in();
      set_id(1, 0, 0, 32'h100, 32'h20, 5'd0, 5'd0, 32'h0);
      ex_valid = 1; ex_taken = 1; ex_predicted = 0; ex_target = 32'h3000;
      #1;
      total++; if (target_pc !== 32'h104) $display("FAIL reset_target got %h exp %h", target_pc, 32'h104); else pass_cnt++;
      total++; if (predict_taken !== 1'b0) $display("FAIL reset_taken got %b exp 0", predict_taken); else pass_cnt++;
      total++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %b exp 0", mispredict); else pass_cnt++;
      total++; if (recover_pc !== 32'h0) $display("FAIL reset_recover got %h exp 0", recover_pc); else pass_cnt++;
      clear_in();
      tick(); tick();
      rst = 1;
      ghr_m = '0;
      set_id(1, 0, 0, 32'h100, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (pred_idx !== 6'd0) $display("FAIL first_idx got %h exp 0", pred_idx); else pass_cnt++;
      total++; if (predict_taken !== 1'b0) $display("FAIL first_taken got %b exp 0", predict_taken); else pass_cnt++;
      total++; if (target_pc !== 32'h104) $display("FAIL first_target got %h exp %h", target_pc, 32'h104); else pass_cnt++;
      clear_in();
   endtask

   // Train entry 0 repeatedly; the probing PC is chosen so pred_idx stays 0 as GHR moves.
   task automatic test_counter_training();
      logic seq_t  [7] = '{1, 1, 1, 0, 0, 0, 0};
      logic exp_pt [7] = '{1, 1, 1, 1, 0, 0, 0};
      logic [31:0] pc;
      logic [31:0] exp_tgt;
      for (int i = 0; i < 7; i++) begin
         train(6'd0, seq_t[i]);
         pc = 32'h100 | (32'(ghr_m) << 2);
         exp_tgt = exp_pt[i] ? pc + 32'h20 : pc + 32'h4;
         set_id(1, 0, 0, pc, 32'h20, 5'd0, 5'd0, 32'h0);
         #1;
         total++; if (pred_idx !== 6'd0) $display("FAIL train_idx[%0d] got %h exp 0", i, pred_idx); else pass_cnt++;
         total++; if (predict_taken !== exp_pt[i]) $display("FAIL train_taken[%0d] got %b exp %b", i, predict_taken, exp_pt[i]); else pass_cnt++;
         total++; if (target_pc !== exp_tgt) $display("FAIL train_target[%0d] got %h exp %h", i, target_pc, exp_tgt); else pass_cnt++;
         id_valid = 0;
      end
      clear_in();
   endtask

   task automatic test_jal_ras();
      set_id(0, 1, 0, 32'h200, 32'h40, 5'd0, 5'd1, 32'h0);
      #1;
      total++; if (predict_taken !== 1'b1) $display("FAIL jal_taken got %b exp 1", predict_taken); else pass_cnt++;
      total++; if (target_pc !== 32'h240) $display("FAIL jal_target got %h exp %h", target_pc, 32'h240); else pass_cnt++;
      tick();
      set_id(0, 0, 1, 32'h240, 32'h0, 5'd1, 5'd0, 32'h5555);
      #1;
      total++; if (target_pc !== 32'h204) $display("FAIL ret_target got %h exp %h", target_pc, 32'h204); else pass_cnt++;
      tick();
      set_id(0, 0, 1, 32'h244, 32'h10, 5'd1, 5'd0, 32'h777);
      #1;
      total++; if (target_pc !== 32'h786) $display("FAIL ret_empty got %h exp %h", target_pc, 32'h786); else pass_cnt++;
      tick();
      clear_in();
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp_tgt;
      for (int i = 0; i < 9; i++) begin
         set_id(0, 1, 0, 32'h1000 + 32'(i) * 32'h10, 32'h100, 5'd0, 5'd1, 32'h0);
         tick();
      end
      for (int j = 0; j < 8; j++) begin
         set_id(0, 0, 1, 32'h2000 + 32'(j) * 32'h4, 32'h0, (j % 2 == 1) ? 5'd5 : 5'd1, 5'd0, 32'hdead0000);
         exp_tgt = 32'h1084 - 32'(j) * 32'h10;
         #1;
         total++; if (target_pc !== exp_tgt) $display("FAIL ras_pop[%0d] got %h exp %h", j, target_pc, exp_tgt); else pass_cnt++;
         tick();
      end
      set_id(0, 0, 1, 32'h2100, 32'h4, 5'd1, 5'd0, 32'h3001);
      #1;
      total++; if (target_pc !== 32'h3004) $display("FAIL ras_underflow got %h exp %h", target_pc, 32'h3004); else pass_cnt++;
      tick();
      clear_in();
   endtask

   task automatic test_ras_replace();
      set_id(0, 1, 0, 32'h700, 32'h80, 5'd0, 5'd1, 32'h0);
      tick();
      set_id(0, 0, 1, 32'h800, 32'h0, 5'd1, 5'd5, 32'h0);
      #1;
      total++; if (target_pc !== 32'h704) $display("FAIL replace_pop got %h exp %h", target_pc, 32'h704); else pass_cnt++;
      tick();
      set_id(0, 0, 1, 32'h900, 32'h0, 5'd5, 5'd0, 32'h0);
      #1;
      total++; if (target_pc !== 32'h804) $display("FAIL replace_top got %h exp %h", target_pc, 32'h804); else pass_cnt++;
      tick();
      set_id(0, 0, 1, 32'h904, 32'h0, 5'd1, 5'd0, 32'h11);
      #1;
      total++; if (target_pc !== 32'h10) $display("FAIL replace_count got %h exp %h", target_pc, 32'h10); else pass_cnt++;
      tick();
      clear_in();
   endtask

   task automatic test_mispredict();
      stall = 1;
      ex_valid = 1; ex_taken = 1; ex_predicted = 0; ex_target = 32'h3000; ex_pc = 32'h500;
      #1;
      total++; if (mispredict !== 1'b1) $display("FAIL mp_taken got %b exp 1", mispredict); else pass_cnt++;
      total++; if (recover_pc !== 32'h3000) $display("FAIL mp_taken_pc got %h exp %h", recover_pc, 32'h3000); else pass_cnt++;
      ex_taken = 0; ex_predicted = 1; ex_pc = 32'h400;
      #1;
      total++; if (mispredict !== 1'b1) $display("FAIL mp_nt got %b exp 1", mispredict); else pass_cnt++;
      total++; if (recover_pc !== 32'h404) $display("FAIL mp_nt_pc got %h exp %h", recover_pc, 32'h404); else pass_cnt++;
      ex_taken = 1; ex_predicted = 1;
      #1;
      total++; if (mispredict !== 1'b0) $display("FAIL mp_agree got %b exp 0", mispredict); else pass_cnt++;
      ex_valid = 0; ex_taken = 0; ex_predicted = 1;
      #1;
      total++; if (mispredict !== 1'b0) $display("FAIL mp_novalid got %b exp 0", mispredict); else pass_cnt++;
      clear_in();
      stall = 0;
      tick();
   endtask

   task automatic test_stall();
      logic [31:0] pc;
      stall = 1;
      ex_valid = 1; ex_idx = 6'd0; ex_taken = 1; ex_predicted = 1;
      set_id(0, 1, 0, 32'h600, 32'h10, 5'd0, 5'd1, 32'h0);
      #1;
      total++; if (target_pc !== 32'h610) $display("FAIL stall_comb got %h exp %h", target_pc, 32'h610); else pass_cnt++;
      tick(); tick(); tick();
      clear_in();
      stall = 0;
      pc = 32'h100 | (32'(ghr_m) << 2);
      set_id(1, 0, 0, pc, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (pred_idx !== 6'd0) $display("FAIL stall_ghr got %h exp 0", pred_idx); else pass_cnt++;
      total++; if (predict_taken !== 1'b0) $display("FAIL stall_ctr got %b exp 0", predict_taken); else pass_cnt++;
      set_id(0, 0, 1, 32'h680, 32'h0, 5'd1, 5'd0, 32'h900);
      #1;
      total++; if (target_pc !== 32'h900) $display("FAIL stall_ras got %h exp %h", target_pc, 32'h900); else pass_cnt++;
      tick();
      clear_in();
   endtask

   task automatic test_async_reset_ghr();
      logic [5:0] exp_idx;
      exp_idx = 6'd1 ^ ghr_m;
      set_id(1, 0, 0, 32'h104, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (pred_idx !== exp_idx) $display("FAIL pre_rst_idx got %h exp %h", pred_idx, exp_idx); else pass_cnt++;
      rst = 0;
      #1;
      total++; if (pred_idx !== 6'd1) $display("FAIL rst_ghr got %h exp 1", pred_idx); else pass_cnt++;
      total++; if (target_pc !== 32'h108) $display("FAIL rst_target got %h exp %h", target_pc, 32'h108); else pass_cnt++;
      clear_in();
      tick();
      rst = 1;
      ghr_m = '0;
      train(6'd0, 1'b1);
      set_id(1, 0, 0, 32'h104, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (predict_taken !== 1'b1) $display("FAIL rst_ctr got %b exp 1", predict_taken); else pass_cnt++;
      id_valid = 0;
      train(6'd5, 1'b1);
      set_id(1, 0, 0, 32'h150, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (pred_idx !== 6'h17) $display("FAIL gshare_idx got %h exp %h", pred_idx, 6'h17); else pass_cnt++;
      total++; if (predict_taken !== 1'b0) $display("FAIL gshare_taken got %b exp 0", predict_taken); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      ex_valid = 1; ex_idx = 6'h17; ex_taken = 1; ex_predicted = 1;
      set_id(1, 0, 0, 32'h150, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL b2b_pre got %b exp 0", predict_taken); else pass_cnt++;
      tick();
      ex_valid = 0;
      ghr_m = {ghr_m[4:0], 1'b1};
      set_id(1, 0, 0, 32'h140, 32'h20, 5'd0, 5'd0, 32'h0);
      #1;
      total++; if (pred_idx !== 6'h17) $display("FAIL b2b_idx got %h exp %h", pred_idx, 6'h17); else pass_cnt++;
      total++; if (predict_taken !== 1'b1) $display("FAIL b2b_post got %b exp 1", predict_taken); else pass_cnt++;
      total++; if (target_pc !== 32'h160) $display("FAIL b2b_target got %h exp %h", target_pc, 32'h160); else pass_cnt++;
      clear_in();
   endtask

   initial begin
      test_reset();
      test_counter_training();
      test_jal_ras();
      test_ras_overflow();
      test_ras_replace();
      test_mispredict();
      test_stall();
      test_async_reset_ghr();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/branch_predictor_gras.md
Name: branch_predictor_gras

Overview:
- Parametrised next-generation decode-stage branch predictor, instantiated in the ID stage.
- Combines a configurable gshare/bimodal table of 2-bit counters with a return-address stack (RAS).
- Produces a same-cycle predicted next PC for branches, JAL and JALR.
- Trains on resolved branches from EX and reports mispredict plus recovery PC to IF.

Parameters:
- XLEN, 32, data/PC width.
- BHT_ENTRIES, 64, counter count; power of two, >= 4.
- GHR_BITS, 6, global history length; 0 selects pure bimodal; must be <= log2(BHT_ENTRIES).
- RAS_DEPTH, 8, return-stack entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freezes all state updates (dcache/icache stall).
- id_valid  in  1  ID instruction is valid.
- id_pc  in  XLEN  PC of the ID instruction.
- id_imm  in  XLEN  sign-extended immediate.
- id_is_branch  in  1  conditional branch.
- id_is_jal  in  1  JAL.
- id_is_jalr  in  1  JALR.
- id_rs1  in  5  rs1 index.
- id_rd  in  5  rd index.
- id_rs1_data  in  XLEN  register-file rs1 value.
- ex_valid  in  1  resolved branch presented by EX.
- ex_pc  in  XLEN  resolved branch PC.
- ex_target  in  XLEN  resolved taken target.
- ex_taken  in  1  actual outcome.
- ex_predicted  in  1  prediction carried down the pipe.
- ex_idx  in  log2(BHT_ENTRIES)  table index used at prediction.
- target_pc  out  XLEN  predicted next PC.
- predict_taken  out  1  prediction; travels with the instruction.
- pred_idx  out  log2(BHT_ENTRIES)  index used; travels with the instruction.
- mispredict  out  1  flush request to IF/ID.
- recover_pc  out  XLEN  correct PC on mispredict.

Behaviour:
- Reset (rst=0, async): all counters 2'b01 (weakly not-taken); GHR=0; RAS pointer=0, count=0, entries=0.
- Outputs with rst asserted:
  - target_pc = id_pc+4
  - predict_taken = 0
  - mispredict = 0
  - recover_pc = 0
- Index: pred_idx = id_pc[IDXW+1:2] XOR {zero-pad, GHR}. With GHR_BITS=0, pred_idx = id_pc[IDXW+1:2].
- Prediction is combinational from flops, zero latency:
  - Branch: predict_taken = counter[pred_idx][1]; target = taken ? id_pc+id_imm : id_pc+4.
  - JAL: predict_taken=1; target = id_pc+id_imm.
  - JALR pop case (rs1 ∈ {x1,x5} and rs1≠rd): target = RAS top if count>0, else (id_rs1_data+id_imm)&~1.
  - JALR other cases: target = (id_rs1_data+id_imm)&~1.
  - Non-control or id_valid=0: predict_taken=0; target = id_pc+4.
- All PC arithmetic is mod 2^XLEN; wrap-around is permitted and not flagged.
- RAS push: (JAL or JALR) with rd ∈ {x1,x5}; pushes id_pc+4.
- RAS pop: JALR with rs1 ∈ {x1,x5} and rs1≠rd.
- RAS pop+push in the same instruction: top entry is replaced; count unchanged.
- RAS full push: circular; oldest entry overwritten; count saturates at RAS_DEPTH.
- RAS empty pop: count stays 0; pointer unchanged.
- RAS is updated speculatively at ID, only when id_valid & ~stall. It is not repaired on mispredict (accepted accuracy loss).
- Training, on each edge with ex_valid & ~stall:
  - counter[ex_idx] increments if ex_taken, else decrements; saturates at 0 and 3.
  - GHR <= {GHR[GHR_BITS-2:0], ex_taken} (non-speculative).
- Same-cycle read and write to the same index: the ID read sees the pre-update value; the new value is visible next cycle.
- mispredict = ex_valid & (ex_taken ≠ ex_predicted); combinational, independent of stall.
- recover_pc = ex_taken ? ex_target : ex_pc+4.
- stall=1: no counter, GHR or RAS change; combinational outputs still valid.
- Reset asserted mid-operation: all state cleared immediately; the first prediction after release uses reset values.

Decomposition:
- Package bp_pkg:
  - counter typedef (2-bit) and encodings SNT=0, WNT=1, WT=2, ST=3.
  - Link-register constants X1=5'd1, X5=5'd5.
  - Function is_link(reg).
- Sub-module bp_ras (parametrised RAS_DEPTH, XLEN): push/pop/replace, top, count.
- Counter table and GHR stay in the top module.

Test Plan:
- Reset, then branch at pc=0x100, imm=0x20 → predict_taken=0, target_pc=0x104. Train taken twice at ex_idx=pred_idx → same branch predicts taken with target 0x120; a third taken leaves counter at 3; four not-takens give 0 and the prediction stays not-taken.
- JAL at 0x200 with rd=x1 → target 0x200+imm. Then JALR rs1=x1, rd=x0 → target 0x204 and count returns to 0.
- RAS_DEPTH=8: push 9 calls from 0x1000 step 0x10 → 8 pops return 0x1084…0x1014. Ninth pop falls back to id_rs1_data+imm with bit 0 cleared.
- ex_valid with ex_taken=1, ex_predicted=0, ex_target=0x3000 → mispredict=1, recover_pc=0x3000. Opposite case with ex_pc=0x400 → recover_pc=0x404.
- stall=1 for 3 cycles with ex_valid and JAL pushes → counters, GHR and RAS are unchanged after stall drops.
- GHR_BITS=2: after taken, taken, the same pc yields pred_idx = bimodal index XOR 2'b11. Assert rst mid-sequence → GHR=0 and counters=1 immediately.
